// File: rtl/dbus_arbiter_if.sv
// Bundle of every handshake/bus signal around the two-master data bus
// arbiter: both requester ports plus the shared slave-side port.
//   slave  : the arbiter's view (serves the masters, drives the s_* bus)
//   master : the environment's view (requesters and the slave device)
interface dbus_arbiter_if #(
  parameter int AW = 64,
  parameter int DW = 64
);
  // master 0 (CPU data port)
  logic          m0_req;
  logic [AW-1:0] m0_addr;
  logic [DW-1:0] m0_wdata;
  logic          m0_rw;
  logic [1:0]    m0_word;
  logic          m0_ack;
  logic          m0_err;
  logic [DW-1:0] m0_rdata;
  // master 1 (debug loader / DMA)
  logic          m1_req;
  logic [AW-1:0] m1_addr;
  logic [DW-1:0] m1_wdata;
  logic          m1_rw;
  logic [1:0]    m1_word;
  logic          m1_ack;
  logic          m1_err;
  logic [DW-1:0] m1_rdata;
  // shared slave-side port
  logic          s_req;
  logic [AW-1:0] s_addr;
  logic [DW-1:0] s_wdata;
  logic          s_rw;
  logic [1:0]    s_word;
  logic          s_ready;
  logic [DW-1:0] s_rdata;

  modport slave (
    input  m0_req, m0_addr, m0_wdata, m0_rw, m0_word,
    output m0_ack, m0_err, m0_rdata,
    input  m1_req, m1_addr, m1_wdata, m1_rw, m1_word,
    output m1_ack, m1_err, m1_rdata,
    output s_req, s_addr, s_wdata, s_rw, s_word,
    input  s_ready, s_rdata
  );

  modport master (
    output m0_req, m0_addr, m0_wdata, m0_rw, m0_word,
    input  m0_ack, m0_err, m0_rdata,
    output m1_req, m1_addr, m1_wdata, m1_rw, m1_word,
    input  m1_ack, m1_err, m1_rdata,
    input  s_req, s_addr, s_wdata, s_rw, s_word,
    output s_ready, s_rdata
  );
endinterface

// File: rtl/dbus_arbiter.sv
// Two-master round-robin arbiter for the shared data bus. One transaction
// in flight at a time; a slave that never answers is turned into an error
// completion after TIMEOUT cycles.
module dbus_arbiter #(
  parameter int AW      = 64,
  parameter int DW      = 64,
  parameter int TIMEOUT = 16
) (
  input  logic         clk,
  input  logic         rst,
  dbus_arbiter_if.slave bus,
  output logic         owner,
  output logic         busy
);

  localparam int CW = $clog2(TIMEOUT) + 1;

  typedef enum logic [1:0] {IDLE, ISSUE, DONE} state_t;

  state_t        state;
  logic          last_gnt;
  logic [CW-1:0] cnt;

  logic          winner;
  logic [AW-1:0] sel_addr;
  logic [DW-1:0] sel_wdata;
  logic          sel_rw;
  logic [1:0]    sel_word;
  logic          tmo;
  logic          fin;
  logic [DW-1:0] fin_data;
  logic          fin_err;

  // Round-robin pick and field mux for the cycle a request is accepted.
  always_comb begin
    winner = bus.m1_req;
    if (bus.m0_req && bus.m1_req) winner = ~last_gnt;
    sel_addr  = winner ? bus.m1_addr  : bus.m0_addr;
    sel_wdata = winner ? bus.m1_wdata : bus.m0_wdata;
    sel_rw    = winner ? bus.m1_rw    : bus.m0_rw;
    sel_word  = winner ? bus.m1_word  : bus.m0_word;
  end

  // Completion decode during ISSUE; s_ready beats a coincident timeout.
  always_comb begin
    tmo      = (cnt == CW'(TIMEOUT - 1));
    fin      = bus.s_ready || tmo;
    fin_data = bus.s_ready ? bus.s_rdata : {DW{1'b1}};
    fin_err  = ~bus.s_ready;
  end

  // Arbitration FSM; every output is a register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      last_gnt   <= 1'b1;
      cnt        <= '0;
      owner      <= 1'b0;
      busy       <= 1'b0;
      bus.s_req  <= 1'b0;
      bus.s_addr <= '0;
      bus.s_wdata <= '0;
      bus.s_rw   <= 1'b0;
      bus.s_word <= 2'b00;
      bus.m0_ack <= 1'b0;
      bus.m0_err <= 1'b0;
      bus.m0_rdata <= '0;
      bus.m1_ack <= 1'b0;
      bus.m1_err <= 1'b0;
      bus.m1_rdata <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.m0_req || bus.m1_req) begin
            owner       <= winner;
            busy        <= 1'b1;
            cnt         <= '0;
            bus.s_req   <= 1'b1;
            bus.s_addr  <= sel_addr;
            bus.s_wdata <= sel_wdata;
            bus.s_rw    <= sel_rw;
            bus.s_word  <= sel_word;
            state       <= ISSUE;
          end
        end
        ISSUE: begin
          cnt <= cnt + 1'b1;
          if (fin) begin
            bus.s_req <= 1'b0;
            if (owner) begin
              bus.m1_ack   <= 1'b1;
              bus.m1_err   <= fin_err;
              bus.m1_rdata <= fin_data;
            end else begin
              bus.m0_ack   <= 1'b1;
              bus.m0_err   <= fin_err;
              bus.m0_rdata <= fin_data;
            end
            state <= DONE;
          end
        end
        DONE: begin
          // Requests are ignored here so a req still high on the ack
          // cycle is only seen again in IDLE, as a new transaction.
          bus.m0_ack <= 1'b0;
          bus.m1_ack <= 1'b0;
          busy       <= 1'b0;
          last_gnt   <= owner;
          cnt        <= '0;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dbus_arbiter.sv
// Directed bench for dbus_arbiter: single read, alternating tie, write
// pass-through, timeout, ready-on-timeout-cycle, async reset, no re-issue.
module tb_dbus_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   nvec = 0;
  int   nerr = 0;
  int   rises = 0;
  logic sreq_d = 1'b0;

  always #5 clk = ~clk;

  dbus_arbiter_if #(.AW(64), .DW(64)) bus();

  logic owner, busy;

  dbus_arbiter #(.AW(64), .DW(64), .TIMEOUT(16)) dut (
    .clk   (clk),
    .rst   (rst),
    .bus   (bus),
    .owner (owner),
    .busy  (busy)
  );

  // rising edges of s_req = slave transactions started
  always @(posedge clk) begin
    sreq_d <= bus.s_req;
    if (bus.s_req && !sreq_d) rises <= rises + 1;
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_sreq(input string tag);
    int n = 0;
    while (bus.s_req !== 1'b1 && n < 40) begin
      tick();
      n++;
    end
    chk(tag, bus.s_req, 1);
  endtask

  task automatic idle_masters();
    bus.m0_req = 0; bus.m0_addr = '0; bus.m0_wdata = '0; bus.m0_rw = 0; bus.m0_word = 0;
    bus.m1_req = 0; bus.m1_addr = '0; bus.m1_wdata = '0; bus.m1_rw = 0; bus.m1_word = 0;
    bus.s_ready = 0; bus.s_rdata = '0;
  endtask

  initial begin
    int n;
    idle_masters();
    tick();
    tick();
    // reset state
    chk("rst_sreq", bus.s_req, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ack0", bus.m0_ack, 0);
    chk("rst_rdata0", bus.m0_rdata, 0);
    rst = 0;
    tick();

    // ---- single read on m0 ----
    bus.m0_req = 1; bus.m0_addr = 64'h1024; bus.m0_rw = 0; bus.m0_word = 2'b01;
    tick();                                   // ISSUE cycle 1
    chk("rd_sreq", bus.s_req, 1);
    chk("rd_addr", bus.s_addr, 64'h1024);
    chk("rd_word", bus.s_word, 2'b01);
    chk("rd_owner", owner, 0);
    chk("rd_busy", busy, 1);
    tick();                                   // ISSUE cycle 2
    tick();                                   // ISSUE cycle 3: slave answers
    bus.s_ready = 1; bus.s_rdata = 64'hBEEF;
    tick();                                   // DONE
    bus.s_ready = 0; bus.m0_req = 0;
    chk("rd_ack", bus.m0_ack, 1);
    chk("rd_rdata", bus.m0_rdata, 64'hBEEF);
    chk("rd_err", bus.m0_err, 0);
    chk("rd_ack1", bus.m1_ack, 0);
    chk("rd_done_sreq", bus.s_req, 0);
    tick();                                   // IDLE
    chk("rd_ack_pulse", bus.m0_ack, 0);
    chk("rd_rdata_hold", bus.m0_rdata, 64'hBEEF);
    chk("rd_idle_busy", busy, 0);

    // ---- tie after reset: strict alternation m0,m1,m0,m1 ----
    rst = 1; tick(); rst = 0;
    bus.m0_req = 1; bus.m0_addr = 64'h100;
    bus.m1_req = 1; bus.m1_addr = 64'h200;
    for (int i = 0; i < 4; i++) begin
      wait_sreq("tie_sreq");
      chk("tie_owner", owner, i % 2);
      chk("tie_addr", bus.s_addr, (i % 2) ? 64'h200 : 64'h100);
      bus.s_ready = 1; bus.s_rdata = 64'(i);
      tick();                                 // DONE
      bus.s_ready = 0;
      chk("tie_ack0", bus.m0_ack, (i % 2) == 0);
      chk("tie_ack1", bus.m1_ack, (i % 2) == 1);
      if (i == 3) begin bus.m0_req = 0; bus.m1_req = 0; end
      tick();                                 // IDLE
      chk("tie_pulse", {bus.m0_ack, bus.m1_ack}, 0);
    end
    chk("tie_rdata0", bus.m0_rdata, 2);
    chk("tie_rdata1", bus.m1_rdata, 3);

    // ---- write pass-through on m1 ----
    bus.m1_req = 1; bus.m1_addr = 64'h1024; bus.m1_wdata = 64'h1234;
    bus.m1_rw = 1; bus.m1_word = 2'b01;
    wait_sreq("wr_sreq");
    for (int i = 0; i < 3; i++) begin
      chk("wr_rw", bus.s_rw, 1);
      chk("wr_wdata", bus.s_wdata, 64'h1234);
      chk("wr_word", bus.s_word, 2'b01);
      chk("wr_sreq_hold", bus.s_req, 1);
      tick();
    end
    bus.s_ready = 1; bus.s_rdata = 64'h55;
    tick();                                   // DONE
    bus.s_ready = 0; bus.m1_req = 0; bus.m1_rw = 0;
    chk("wr_ack1", bus.m1_ack, 1);
    chk("wr_rdata1", bus.m1_rdata, 64'h55);
    chk("wr_ack0", bus.m0_ack, 0);
    chk("wr_rdata0_kept", bus.m0_rdata, 2);
    tick();

    // ---- timeout on m0 with m1 pending (last_gnt=1, so m0 first) ----
    bus.m0_req = 1; bus.m0_addr = 64'h3000;
    bus.m1_req = 1; bus.m1_addr = 64'h4000;
    wait_sreq("to_sreq");
    chk("to_owner", owner, 0);
    n = 0;
    while (bus.s_req === 1'b1 && n < 40) begin
      tick();
      n++;
    end
    chk("to_len", 64'(n), 16);
    chk("to_ack", bus.m0_ack, 1);
    chk("to_err", bus.m0_err, 1);
    chk("to_rdata", bus.m0_rdata, 64'hFFFF_FFFF_FFFF_FFFF);
    bus.m0_req = 0;
    wait_sreq("to_next_sreq");
    chk("to_next_owner", owner, 1);
    chk("to_next_addr", bus.s_addr, 64'h4000);
    bus.s_ready = 1; bus.s_rdata = 64'h9;
    tick();
    bus.s_ready = 0; bus.m1_req = 0;
    chk("to_next_ack", bus.m1_ack, 1);
    chk("to_next_err", bus.m1_err, 0);
    tick();

    // ---- s_ready on the timeout cycle wins ----
    bus.m0_req = 1;
    wait_sreq("edge_sreq");
    for (int i = 0; i < 15; i++) tick();      // 16th ISSUE cycle
    chk("edge_still", bus.s_req, 1);
    bus.s_ready = 1; bus.s_rdata = 64'h77;
    tick();
    bus.s_ready = 0; bus.m0_req = 0;
    chk("edge_ack", bus.m0_ack, 1);
    chk("edge_err", bus.m0_err, 0);
    chk("edge_rdata", bus.m0_rdata, 64'h77);
    tick();

    // ---- reset mid-ISSUE ----
    bus.m0_req = 1; bus.m1_req = 1;
    wait_sreq("rs_sreq");
    tick();
    #2 rst = 1;
    #1;
    chk("rs_sreq", bus.s_req, 0);
    chk("rs_busy", busy, 0);
    chk("rs_acks", {bus.m0_ack, bus.m1_ack}, 0);
    chk("rs_rdata0", bus.m0_rdata, 0);
    tick();
    rst = 0;
    wait_sreq("rs_after_sreq");
    chk("rs_after_owner", owner, 0);
    bus.s_ready = 1; bus.s_rdata = 64'h1;
    tick();
    bus.s_ready = 0; bus.m0_req = 0; bus.m1_req = 0;
    chk("rs_after_ack", bus.m0_ack, 1);
    tick();
    tick();

    // ---- no double issue: req high through DONE and the IDLE cycle ----
    rises = 0;
    bus.m0_req = 1;
    wait_sreq("nd_sreq");
    bus.s_ready = 1; bus.s_rdata = 64'hA;
    tick();                                   // DONE
    bus.s_ready = 0;
    chk("nd_ack", bus.m0_ack, 1);
    chk("nd_done_sreq", bus.s_req, 0);
    tick();                                   // IDLE, req still high
    chk("nd_idle_sreq", bus.s_req, 0);
    tick();                                   // second transaction
    bus.m0_req = 0;
    chk("nd_second", bus.s_req, 1);
    bus.s_ready = 1; bus.s_rdata = 64'hB;
    tick();
    bus.s_ready = 0;
    chk("nd_ack2", bus.m0_ack, 1);
    for (int i = 0; i < 6; i++) tick();
    chk("nd_count", 64'(rises), 2);
    chk("nd_rdata", bus.m0_rdata, 64'hB);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

  // hard stop so the run can never hang
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

endmodule

// File: doc/dbus_arbiter.md
Name: dbus_arbiter

Overview:
- Two-master arbiter for the shared 64-bit data bus port.
- Master 0 is the CPU data port (daddr/wdata/rw/word/ddata); master 1 is a secondary requester (debug loader or DMA).
- Serialises both masters onto one slave-side port feeding the bus/peripheral decode (memory, gpio, seg7 register).
- Uses round-robin priority, one outstanding transaction at a time, and a response timeout that converts a hung slave into an error response.

Parameters:
- AW, 64, address width.
- DW, 64, data width.
- TIMEOUT, 16, maximum cycles to wait for s_ready before aborting (must be >= 2).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous active-high reset.
- m0_req  in  1  master 0 request; held high until m0_ack.
- m0_addr  in  AW  master 0 address.
- m0_wdata  in  DW  master 0 write data.
- m0_rw  in  1  1 = write, 0 = read.
- m0_word  in  2  access size: 00 byte, 01 half, 10 word, 11 double.
- m0_ack  out  1  one-cycle completion pulse.
- m0_err  out  1  valid with m0_ack; 1 = timed out.
- m0_rdata  out  DW  read data; valid with m0_ack.
- m1_req, m1_addr, m1_wdata, m1_rw, m1_word, m1_ack, m1_err, m1_rdata: identical to the m0 ports, for master 1.
- s_req  out  1  slave request.
- s_addr  out  AW  slave address.
- s_wdata  out  DW  slave write data.
- s_rw  out  1  slave direction.
- s_word  out  2  slave access size.
- s_ready  in  1  slave completion; s_rdata valid in the same cycle.
- s_rdata  in  DW  slave read data.
- owner  out  1  master currently granted; meaningful only while busy.
- busy  out  1  high in ISSUE and DONE.

Behaviour:
- Reset values: all outputs 0, state IDLE, last_gnt = 1 (so m0 wins the first tie), timeout counter 0.
- State IDLE:
  - If any req is high, pick the winner: sole requester, otherwise the master != last_gnt.
  - Register the winner's addr/wdata/rw/word into the s_* outputs and set owner = winner; go to ISSUE.
  - Slave-side signals are registered, so s_req rises the cycle after req is sampled.
- State ISSUE:
  - s_req = 1 and s_* are held stable; counter increments each cycle.
  - If s_ready = 1: capture s_rdata into the owner's rdata (writes capture it too), err = 0, go to DONE.
  - Else if counter == TIMEOUT-1: owner's rdata = all ones, err = 1, go to DONE.
  - s_ready wins if it coincides with the timeout cycle.
- State DONE (exactly one cycle):
  - Owner's ack = 1; s_req = 0; last_gnt = owner; counter cleared; go to IDLE.
  - Requests are not sampled in DONE, so a req still high on the ack cycle is never double-issued.
- Latency: req high at cycle N in IDLE -> s_req from N+1; s_ready at cycle M -> ack at M+1. Minimum 3 cycles from req to ack.
- rdata/err hold their value until the next completion for that master. The non-owner's ack, rdata and err are untouched.
- Master rules:
  - Keep req and the transaction fields stable until ack.
  - A req high in the cycle after ack is a new transaction.
  - Dropping req mid-transaction does not abort it; ack is still issued.
- Fairness: with both masters continuously requesting, grants strictly alternate. A single requester gets back-to-back service with a 1-cycle IDLE gap.
- Reset mid-transaction: all state and outputs return to reset values immediately (asynchronous); s_req drops without waiting for the slave; no ack is issued.
- s_ready outside ISSUE is ignored.

Test Plan:
- Single read: m0_req, addr 0x1024, rw 0, word 01; slave returns s_ready with 0xBEEF 2 cycles after s_req -> s_addr = 0x1024, m0_ack one cycle with m0_rdata = 0xBEEF, m0_err = 0, m1_ack stays 0.
- Tie after reset: m0 and m1 request together, both held continuously -> grant order m0, m1, m0, m1; owner toggles; each ack is a single cycle.
- Write pass-through: m1 writes 0x1234, word 01 to 0x1024 -> s_rw = 1 and s_wdata = 0x1234 held stable for the whole ISSUE state; m1_ack one cycle after s_ready.
- Timeout: s_ready never asserted, TIMEOUT = 16 -> s_req high for exactly 16 cycles; m0_ack with m0_err = 1 and m0_rdata = 0xFFFF_FFFF_FFFF_FFFF; then m1 (pending) is granted.
- Reset mid-ISSUE: assert rst between clock edges during ISSUE -> s_req, busy and both acks go to 0 immediately; after release, m0 wins the first tie.
- No double issue: m0_req left high through its ack cycle and one more cycle -> exactly two slave transactions, separated by the DONE and IDLE cycles.
